// File: rtl/shift_seq_ctrl.sv
// Multi-cycle sequencer giving a 31-per-pass barrel shifter full ARM operand-2 shift semantics.
// Define SHIFT_SEQ_SINGLE_STEP_EN to resolve every shift amount in a single SHIFT cycle.
module shift_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] operand,
  input  logic [1:0]  shift_type,
  input  logic [7:0]  amount,
  input  logic        reg_shift,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
  typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} shift_t;

  state_t      state_q, state_d;
  logic [31:0] work_q;
  shift_t      type_q;
  logic        cin_q;
  logic        rrx_q;
  logic [7:0]  rem_q;

  logic        accept;
  logic [7:0]  eff_amount;
  logic        is_rrx;
  logic [7:0]  shamt;
  logic        last_step;
  logic [32:0] lsl_ext, lsr_ext, asr_ext;
  logic [31:0] ror_res;
  logic [31:0] step_res;
  logic        step_c;

  assign accept = start && (state_q != ST_SHIFT);

  // Immediate #0 is not a null shift for LSR/ASR (means #32) or ROR (means RRX).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    eff_amount = 8'd0;
    is_rrx     = 1'b0;
    if (reg_shift) begin
      eff_amount = amount;
    end else if (amount[4:0] != 5'd0) begin
      eff_amount = {3'b000, amount[4:0]};
    end else begin
      case (shift_t'(shift_type))
        SH_LSR, SH_ASR: eff_amount = 8'd32;
        SH_ROR:         is_rrx     = 1'b1;
        default:        eff_amount = 8'd0;
      endcase
    end
  end

`ifdef SHIFT_SEQ_SINGLE_STEP_EN
  assign shamt     = rem_q;
  assign last_step = 1'b1;
`else
  assign shamt     = (rem_q > 8'd31) ? 8'd31 : rem_q;
  assign last_step = rrx_q || (rem_q <= 8'd31);
`endif

  // The 33-bit extensions carry the last bit shifted out alongside the result,
  // so amounts of 32 and above fall out of the plain shift operators.
  assign lsl_ext = {1'b0, work_q} << shamt;
  assign lsr_ext = {work_q, 1'b0} >> shamt;
  assign asr_ext = $signed({work_q, 1'b0}) >>> shamt;
  assign ror_res = (work_q >> shamt[4:0]) | (work_q << (6'd32 - {1'b0, shamt[4:0]}));

  always_comb begin
    step_res = work_q;
    step_c   = cin_q;
    if (rrx_q) begin
      step_res = {cin_q, work_q[31:1]};
      step_c   = work_q[0];
    end else begin
      case (type_q)
        SH_LSL: begin step_res = lsl_ext[31:0]; step_c = lsl_ext[32]; end
        SH_LSR: begin step_res = lsr_ext[32:1]; step_c = lsr_ext[0];  end
        SH_ASR: begin step_res = asr_ext[32:1]; step_c = asr_ext[0];  end
        SH_ROR: begin step_res = ror_res;       step_c = ror_res[31]; end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done    = (state_q == ST_DONE);
        state_d = ST_IDLE;
        if (accept) begin
          state_d = (eff_amount == 8'd0 && !is_rrx) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_step) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q    <= 32'd0;
      type_q    <= SH_LSL;
      cin_q     <= 1'b0;
      rrx_q     <= 1'b0;
      rem_q     <= 8'd0;
      result    <= 32'd0;
      carry_out <= 1'b0;
    end else if (accept) begin
      work_q <= operand;
      type_q <= shift_t'(shift_type);
      cin_q  <= carry_in;
      rrx_q  <= is_rrx;
      rem_q  <= eff_amount;
      if (eff_amount == 8'd0 && !is_rrx) begin
        result    <= operand;
        carry_out <= carry_in;
      end
    end else if (state_q == ST_SHIFT) begin
      work_q <= step_res;
      rem_q  <= rem_q - shamt;
      // Outputs move only on completion so they stay stable while done is high.
      if (last_step) begin
        result    <= step_res;
        carry_out <= step_c;
      end
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed table-driven bench for shift_seq_ctrl, plus back-to-back and mid-shift reset sequences.
// Expected latencies follow SHIFT_SEQ_SINGLE_STEP_EN when it is defined for the build.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] operand;
  logic [1:0]  shift_type;
  logic [7:0]  amount;
  logic        reg_shift;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  int n_checks = 0;
  int n_errors = 0;

  shift_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .operand    (operand),
    .shift_type (shift_type),
    .amount     (amount),
    .reg_shift  (reg_shift),
    .carry_in   (carry_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry_out  (carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rs;
    logic [1:0]  ty;
    logic [7:0]  amt;
    logic [31:0] op;
    logic        cin;
    logic [31:0] exp_res;
    logic        exp_c;
    int          lat_it;
    int          lat_ss;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic run_op(input logic rs, input logic [1:0] ty, input logic [7:0] amt,
                        input logic [31:0] op, input logic cin, input logic [31:0] exp_res,
                        input logic exp_c, input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    reg_shift  = rs;
    shift_type = ty;
    amount     = amt;
    operand    = op;
    carry_in   = cin;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_done"},   {31'd0, done},      32'd1);
    check({tag, "_result"}, result,             exp_res);
    check({tag, "_carry"},  {31'd0, carry_out}, {31'd0, exp_c});
    check({tag, "_lat"},    lat,                exp_lat);
    @(posedge clk);
    #1;
    check({tag, "_pulse"},  {31'd0, done},      32'd0);
  endtask

  initial begin
    vq.push_back('{1'b1, 2'b00, 8'd32,  32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 3,  2});
    vq.push_back('{1'b1, 2'b10, 8'd200, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 8,  2});
    vq.push_back('{1'b0, 2'b11, 8'd0,   32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1, 2,  2});
    vq.push_back('{1'b1, 2'b11, 8'd64,  32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 4,  2});
    vq.push_back('{1'b1, 2'b01, 8'd0,   32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1,  1});
    vq.push_back('{1'b0, 2'b00, 8'd0,   32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 1'b0, 1,  1});
    vq.push_back('{1'b0, 2'b01, 8'd0,   32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1, 3,  2});
    vq.push_back('{1'b0, 2'b10, 8'd0,   32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 3,  2});
    vq.push_back('{1'b1, 2'b00, 8'd31,  32'h0000_0003, 1'b0, 32'h8000_0000, 1'b1, 2,  2});
    vq.push_back('{1'b1, 2'b01, 8'd33,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 3,  2});
    vq.push_back('{1'b0, 2'b00, 8'd4,   32'h1234_5678, 1'b0, 32'h2345_6780, 1'b1, 2,  2});
    vq.push_back('{1'b1, 2'b11, 8'd8,   32'h1234_5678, 1'b1, 32'h7812_3456, 1'b0, 2,  2});
    vq.push_back('{1'b1, 2'b10, 8'd255, 32'h4000_0000, 1'b1, 32'h0000_0000, 1'b0, 10, 2});
    vq.push_back('{1'b0, 2'b11, 8'd4,   32'h0000_000F, 1'b0, 32'hF000_0000, 1'b1, 2,  2});
    vq.push_back('{1'b1, 2'b01, 8'd32,  32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 3,  2});
    vq.push_back('{1'b0, 2'b01, 8'hFF,  32'h8000_0000, 1'b0, 32'h0000_0001, 1'b0, 2,  2});
    vq.push_back('{1'b1, 2'b11, 8'd33,  32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1, 3,  2});
    vq.push_back('{1'b1, 2'b10, 8'd31,  32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, 2,  2});

    rst_n      = 1'b0;
    start      = 1'b0;
    operand    = 32'd0;
    shift_type = 2'b00;
    amount     = 8'd0;
    reg_shift  = 1'b0;
    carry_in   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   {31'd0, busy},      32'd0);
    check("rst_done",   {31'd0, done},      32'd0);
    check("rst_result", result,             32'd0);
    check("rst_carry",  {31'd0, carry_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
`ifdef SHIFT_SEQ_SINGLE_STEP_EN
      run_op(vq[i].rs, vq[i].ty, vq[i].amt, vq[i].op, vq[i].cin, vq[i].exp_res, vq[i].exp_c,
             vq[i].lat_ss, $sformatf("vec%0d", i));
`else
      run_op(vq[i].rs, vq[i].ty, vq[i].amt, vq[i].op, vq[i].cin, vq[i].exp_res, vq[i].exp_c,
             vq[i].lat_it, $sformatf("vec%0d", i));
`endif
    end

    // Back-to-back: the held start is ignored while busy, then accepted in DONE.
    @(negedge clk);
    reg_shift  = 1'b0;
    shift_type = 2'b01;
    amount     = 8'd4;
    operand    = 32'h0000_00F0;
    carry_in   = 1'b0;
    start      = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_busy0", {31'd0, busy}, 32'd1);
    shift_type = 2'b00;
    amount     = 8'd1;
    operand    = 32'h0000_0001;
    @(posedge clk);
    #1;
    check("b2b_done1",   {31'd0, done},      32'd1);
    check("b2b_res1",    result,             32'h0000_000F);
    check("b2b_carry1",  {31'd0, carry_out}, 32'd0);
    check("b2b_busy1",   {31'd0, busy},      32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_gap_done", {31'd0, done}, 32'd0);
    check("b2b_gap_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("b2b_done2",  {31'd0, done},      32'd1);
    check("b2b_res2",   result,             32'h0000_0002);
    check("b2b_carry2", {31'd0, carry_out}, 32'd0);
    @(posedge clk);
    #1;
    check("b2b_idle_done", {31'd0, done}, 32'd0);
    check("b2b_idle_busy", {31'd0, busy}, 32'd0);

    // Reset mid-SHIFT of a 255 shift aborts it without a done pulse.
    @(negedge clk);
    reg_shift  = 1'b1;
    shift_type = 2'b00;
    amount     = 8'd255;
    operand    = 32'h0000_0001;
    carry_in   = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy",   {31'd0, busy},      32'd0);
    check("rst_mid_done",   {31'd0, done},      32'd0);
    check("rst_mid_result", result,             32'd0);
    check("rst_mid_carry",  {31'd0, carry_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_quiet%0d", i), {30'd0, busy, done}, 32'd0);
    end
    run_op(1'b1, 2'b00, 8'd1, 32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1, 2, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Multi-cycle sequencer for the 5-bit barrel-shift datapath (LSL/LSR/ASR/ROR, amounts 0–31 per pass). It gives the shifter full ARM operand-2 semantics: register-specified amounts of 0–255, immediate-encoding special cases (LSR/ASR #32, RRX), and shifter carry-out. It runs the datapath in steps of at most 31 positions per cycle. It sits between decode and the ALU operand-2 input, and stalls issue via `busy` while a shift is in flight.

## Interface
- No parameters.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request strobe; accepted only when `busy`=0.
- `operand`  in  32  value to shift (Rm).
- `shift_type`  in  2  00 LSL, 01 LSR, 10 ASR (arithmetic), 11 ROR.
- `amount`  in  8  shift amount; register mode uses all 8 bits, immediate mode uses `amount[4:0]` only.
- `reg_shift`  in  1  1 = register-specified semantics, 0 = immediate semantics.
- `carry_in`  in  1  current C flag.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  32  shifted value; held until the next completion.
- `carry_out`  out  1  shifter carry; held with `result`.

## Operation
- States: IDLE, SHIFT, DONE. `busy` = (state==SHIFT). `done` = (state==DONE).
- Accept: `start`=1 in IDLE or DONE. This latches `operand`, `shift_type`, `carry_in`, and the effective amount `rem`. A `start` while in SHIFT is ignored (no queueing).
- Effective amount:
  - Register mode: `rem`=`amount` (0–255).
  - Immediate mode, `amount[4:0]`≠0: `rem`=`amount[4:0]`.
  - Immediate mode, LSL #0: `rem`=0.
  - Immediate mode, LSR/ASR #0: `rem`=32.
  - Immediate mode, ROR #0: RRX.
- `rem`=0 at accept: go straight to DONE with `result`=operand and `carry_out`=carry_in. This includes register ROR by 0.
- RRX: one SHIFT cycle. `result`={carry_in, op[31:1]}, `carry_out`=op[0].
- SHIFT cycle: step = min(`rem`, 31). Apply the step to the working register with the latched type, then `rem` -= step. `carry_out` = last bit shifted out (LSL: bit 32−step; LSR/ASR: bit step−1; ROR: new result[31]). When `rem` reaches 0, go to DONE.
- Steps accumulate naturally, which gives the required results:
  - LSL/LSR by 32: result 0, carry = op[0] (LSL) or op[31] (LSR).
  - LSL/LSR by >32: result 0, carry 0.
  - ASR by ≥32: all bits = op[31], carry = op[31].
  - ROR by a nonzero multiple of 32: result = op, carry = op[31].
- DONE lasts one cycle, then returns to IDLE unless a new `start` is accepted.
- `result` and `carry_out` update only on completion and are stable whenever `done`=1.

## Timing
- Reset (async, `rst_n`=0): state IDLE, `busy`=0, `done`=0, `result`=0, `carry_out`=0. Reset during SHIFT aborts the operation; no `done` is produced.
- Edge count from the accepting edge E0 to the first edge at which `done`=1 is L = 1 + N.
  - N = ceil(rem/31) SHIFT cycles.
  - N = 1 for RRX.
  - N = 0 when `rem`=0.
- Example: rem=0 → L=1; rem=31 → L=2; rem=32 → L=3; rem=255 → L=10.
- Back-to-back: `start` in the DONE cycle is accepted. The next operation's SHIFT begins at the following edge; no idle bubble.
- `busy` rises the edge after acceptance (when N>0) and falls on the edge that enters DONE.

## Configuration
- `SHIFT_SEQ_SINGLE_STEP_EN` defined: the datapath handles any effective amount in one SHIFT cycle. Shifts of ≥32 are resolved directly, and ROR uses `rem[4:0]` with the multiple-of-32 rule above. L = 2 for every nonzero shift and RRX; L = 1 for `rem`=0. Results and carries are identical to the iterative build.
- Not defined: iterative 31-per-cycle behaviour as specified above.

## Test plan
- Register LSL, op=0x0000_0001, amount=32, carry_in=0 → result 0x0000_0000, carry_out 1, L=3 (L=2 with macro).
- Register ASR, op=0x8000_0000, amount=200 → result 0xFFFF_FFFF, carry_out 1, L=8 (L=2 with macro).
- Immediate ROR #0 (RRX), op=0x0000_0003, carry_in=1 → result 0x8000_0001, carry_out 1, L=2.
- Register ROR by 64, op=0x1234_5678, carry_in=0 → result 0x1234_5678, carry_out 0, L=4 (2 with macro); register LSR by 0, carry_in=1 → result=op, carry_out 1, L=1.
- Back-to-back: immediate LSR #4 on 0xF0, then `start` held during DONE with LSL #1 on 0x1 → done pulses on two consecutive operations (0x0F then 0x2); a `start` while `busy` is ignored.
- Assert `rst_n`=0 mid-SHIFT of a 255 shift → all outputs 0 immediately, no `done`; a new request after release completes normally.
